// File: rtl/warp_pkg.sv
// warp_pkg: shared types for the fetch queue between fetch and decode.
package warp_pkg;
    typedef logic [31:0] inst_t;
    typedef struct packed {
        inst_t inst;
        logic  compressed;
    } fq_entry_t;
    localparam int BUNDLE_W = 2;
endpackage

// File: rtl/warp_fetch_queue.sv
// warp_fetch_queue: circular instruction queue taking 0-2 fetched instructions per cycle
// and presenting the two oldest to decode; redirect flush drops everything queued.
module warp_fetch_queue
    import warp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_input_valid,
    output logic        o_input_ready,
    input  logic [31:0] i_inst0,
    input  logic [31:0] i_inst1,
    input  logic [1:0]  i_compressed,
    input  logic [1:0]  i_count,
    output logic        o_output_valid,
    input  logic        i_output_ready,
    output logic [31:0] o_inst0,
    output logic [31:0] o_inst1,
    output logic [1:0]  o_compressed,
    output logic [1:0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    fq_entry_t         mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [AW:0]       occ, enq_n, deq_n;
    logic              enq, deq;

    assign rd_nxt         = rd_ptr + 1'b1;
    assign wr_nxt         = wr_ptr + 1'b1;
    assign o_output_valid = occ != '0;
    // Ready only when a full bundle fits, regardless of any same-cycle dequeue.
    assign o_input_ready  = occ <= (AW+1)'(DEPTH - BUNDLE_W);
    assign o_count        = occ >= (AW+1)'(BUNDLE_W) ? 2'd2 : occ[1:0];
    assign o_inst0        = mem[rd_ptr].inst;
    assign o_inst1        = mem[rd_nxt].inst;
    assign o_compressed   = {mem[rd_nxt].compressed, mem[rd_ptr].compressed};

    assign enq   = i_input_valid && o_input_ready && !i_flush;
    assign deq   = o_output_valid && i_output_ready && !i_flush;
    assign enq_n = enq ? (AW+1)'(i_count) : '0;
    assign deq_n = deq ? (AW+1)'(o_count) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_flush) begin
            occ    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            occ    <= occ + enq_n - deq_n;
            rd_ptr <= rd_ptr + deq_n[AW-1:0];
            wr_ptr <= wr_ptr + enq_n[AW-1:0];
            if (enq && i_count != 2'd0) mem[wr_ptr] <= '{inst: i_inst0, compressed: i_compressed[0]};
            if (enq && i_count[1]) mem[wr_nxt] <= '{inst: i_inst1, compressed: i_compressed[1]};
        end
    end
endmodule
